// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared widths, memory-FSM states and pipeline-register layouts
//            for the EX/MEM -> MEM/WB writeback path.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned REG_W  = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic              valid;
        logic              RegWrite;
        logic              MemRead;
        logic              MemWrite;
        logic              MemToReg;
        logic [REG_W-1:0]  Rw;
        logic [DATA_W-1:0] Result;
        logic [DATA_W-1:0] StoreData;
    } exmem_t;

    typedef struct packed {
        logic              valid;
        logic              RegWrite;
        logic [REG_W-1:0]  Rw;
        logic [DATA_W-1:0] Data;
    } memwb_t;

endpackage
`default_nettype wire

// File: rtl/pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg
// Brief    : Pipeline register with async reset, hold (en=0) and bubble clear.
// Revision : 1.0
// ============================================================================
module pipe_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Clear wins over load so a bubble never carries stale data fields.
    always_comb begin
        data_d = data_q;
        if (i_en) begin
            data_d = i_clr ? '0 : i_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign o_q = data_q;

endmodule
`default_nettype wire

// File: rtl/mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_pipe
// Brief    : EX/MEM and MEM/WB registers, data-memory handshake with timeout,
//            bypass sources and load-use / memory-wait stall generation.
// Revision : 1.0
// ============================================================================
module mem_wb_pipe
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_RegWrite,
    input  logic              ex_MemRead,
    input  logic              ex_MemWrite,
    input  logic              ex_MemToReg,
    input  logic [REG_W-1:0]  ex_Rw,
    input  logic [DATA_W-1:0] ex_ALUResult,
    input  logic [DATA_W-1:0] ex_StoreData,
    input  logic              flush,
    input  logic [REG_W-1:0]  id_Ra,
    input  logic [REG_W-1:0]  id_Rb,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              EX_MEM_RegWrite,
    output logic [REG_W-1:0]  EX_MEM_Rw,
    output logic [DATA_W-1:0] EX_MEM_Result,
    output logic              MEM_WB_RegWrite,
    output logic [REG_W-1:0]  MEM_WB_Rw,
    output logic [DATA_W-1:0] MEM_WB_Data,
    output logic              lu_stall,
    output logic              mem_stall,
    output logic              mem_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    exmem_t           exmem_d, exmem_q;
    memwb_t           memwb_d, memwb_q;
    mem_state_t       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             err_d, err_q;
    logic             w_mem_op;
    logic             w_abort;

    always_comb begin
        exmem_d           = '0;
        exmem_d.valid     = ex_valid;
        exmem_d.RegWrite  = ex_RegWrite;
        exmem_d.MemRead   = ex_MemRead;
        exmem_d.MemWrite  = ex_MemWrite;
        exmem_d.MemToReg  = ex_MemToReg;
        exmem_d.Rw        = ex_Rw;
        exmem_d.Result    = ex_ALUResult;
        exmem_d.StoreData = ex_StoreData;

        memwb_d          = '0;
        memwb_d.valid    = exmem_q.valid;
        memwb_d.RegWrite = exmem_q.RegWrite;
        memwb_d.Rw       = exmem_q.Rw;
        memwb_d.Data     = exmem_q.MemToReg ? mem_rdata : exmem_q.Result;
    end

    assign w_mem_op  = exmem_q.valid & (exmem_q.MemRead | exmem_q.MemWrite);
    assign w_abort   = (state_q == ABORT);
    assign mem_stall = w_mem_op & ~mem_ready & ~w_abort;

    // Flush only takes effect once the stage is free to advance.
    pipe_reg #(.WIDTH($bits(exmem_t))) u_exmem (
        .clk   (clk),
        .rst   (reset),
        .i_en  (~mem_stall),
        .i_clr (flush | ~ex_valid),
        .i_d   (exmem_d),
        .o_q   (exmem_q)
    );

    pipe_reg #(.WIDTH($bits(memwb_t))) u_memwb (
        .clk   (clk),
        .rst   (reset),
        .i_en  (1'b1),
        .i_clr (mem_stall | w_abort),
        .i_d   (memwb_d),
        .o_q   (memwb_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (w_mem_op && !mem_ready) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == c_cnt_last) begin
                    // This cycle is the TIMEOUT-th stalled cycle; give up.
                    state_d = ABORT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ABORT: begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign mem_addr        = exmem_q.Result;
    assign mem_wdata       = exmem_q.StoreData;
    assign mem_read        = exmem_q.valid & exmem_q.MemRead & ~w_abort;
    assign mem_write       = exmem_q.valid & exmem_q.MemWrite & ~w_abort;
    assign EX_MEM_RegWrite = exmem_q.valid & exmem_q.RegWrite & (exmem_q.Rw != ZERO_REG);
    assign EX_MEM_Rw       = exmem_q.Rw;
    assign EX_MEM_Result   = exmem_q.Result;
    assign MEM_WB_RegWrite = memwb_q.valid & memwb_q.RegWrite & (memwb_q.Rw != ZERO_REG);
    assign MEM_WB_Rw       = memwb_q.Rw;
    assign MEM_WB_Data     = memwb_q.Data;
    assign mem_err         = err_q;

    assign lu_stall = ex_valid & ex_MemRead & ex_RegWrite & (ex_Rw != ZERO_REG) &
                      ((ex_Rw == id_Ra) | (ex_Rw == id_Rb));

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_pipe
// Brief    : Directed self-checking bench for mem_wb_pipe.
// Revision : 1.0
// ============================================================================
module tb_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg;
    logic [4:0]  ex_Rw;
    logic [63:0] ex_ALUResult, ex_StoreData;
    logic        flush;
    logic [4:0]  id_Ra, id_Rb;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_read, mem_write;
    logic        EX_MEM_RegWrite;
    logic [4:0]  EX_MEM_Rw;
    logic [63:0] EX_MEM_Result;
    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_Rw;
    logic [63:0] MEM_WB_Data;
    logic        lu_stall, mem_stall, mem_err;

    int total = 0;
    int bad   = 0;
    int nstall;

    mem_wb_pipe #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_MemToReg(ex_MemToReg), .ex_Rw(ex_Rw),
        .ex_ALUResult(ex_ALUResult), .ex_StoreData(ex_StoreData), .flush(flush),
        .id_Ra(id_Ra), .id_Rb(id_Rb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_Rw(EX_MEM_Rw),
        .EX_MEM_Result(EX_MEM_Result), .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .MEM_WB_Rw(MEM_WB_Rw), .MEM_WB_Data(MEM_WB_Data), .lu_stall(lu_stall),
        .mem_stall(mem_stall), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic rw, input logic rd, input logic wr,
                          input logic m2r, input logic [4:0] rd_idx,
                          input logic [63:0] res, input logic [63:0] sd);
        ex_valid     = v;
        ex_RegWrite  = rw;
        ex_MemRead   = rd;
        ex_MemWrite  = wr;
        ex_MemToReg  = m2r;
        ex_Rw        = rd_idx;
        ex_ALUResult = res;
        ex_StoreData = sd;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        id_Ra = 5'd0;
        id_Rb = 5'd0;
        mem_rdata = 64'h0;
        mem_ready = 1'b1;
        set_ex(0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0);
        tick();
        tick();
        chk("rst_exmem_we", EX_MEM_RegWrite, 1'b0);
        chk("rst_memwb_we", MEM_WB_RegWrite, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_err", mem_err, 1'b0);
        reset = 1'b0;

        // ALU op X3 = 5
        set_ex(1, 1, 0, 0, 0, 5'd3, 64'h5, 64'h0);
        tick();
        set_ex(0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0);
        chk("alu_exmem_we", EX_MEM_RegWrite, 1'b1);
        chk("alu_exmem_rw", EX_MEM_Rw, 5'd3);
        chk("alu_exmem_res", EX_MEM_Result, 64'h5);
        chk("alu_memwb_we_early", MEM_WB_RegWrite, 1'b0);
        tick();
        chk("alu_memwb_we", MEM_WB_RegWrite, 1'b1);
        chk("alu_memwb_rw", MEM_WB_Rw, 5'd3);
        chk("alu_memwb_data", MEM_WB_Data, 64'h5);
        chk("alu_exmem_bubble", EX_MEM_RegWrite, 1'b0);

        // Write to XZR never enables a write
        set_ex(1, 1, 0, 0, 0, 5'd31, 64'h7, 64'h0);
        tick();
        set_ex(0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0);
        chk("xzr_exmem_we", EX_MEM_RegWrite, 1'b0);
        chk("xzr_exmem_rw", EX_MEM_Rw, 5'd31);
        tick();
        chk("xzr_memwb_we", MEM_WB_RegWrite, 1'b0);
        chk("xzr_memwb_rw", MEM_WB_Rw, 5'd31);

        // Load-use detection
        set_ex(1, 1, 1, 0, 1, 5'd2, 64'h0, 64'h0);
        id_Rb = 5'd2;
        #1;
        chk("lu_hit_rb", lu_stall, 1'b1);
        ex_Rw = 5'd31;
        id_Rb = 5'd31;
        #1;
        chk("lu_xzr", lu_stall, 1'b0);
        ex_Rw = 5'd2;
        id_Rb = 5'd5;
        id_Ra = 5'd2;
        #1;
        chk("lu_hit_ra", lu_stall, 1'b1);
        id_Ra = 5'd6;
        #1;
        chk("lu_miss", lu_stall, 1'b0);
        id_Ra = 5'd0;
        id_Rb = 5'd0;

        // Load X2 @0x40 with three wait cycles
        set_ex(1, 1, 1, 0, 1, 5'd2, 64'h40, 64'h0);
        mem_ready = 1'b0;
        tick();
        set_ex(1, 1, 0, 0, 0, 5'd4, 64'h9, 64'h0);
        chk("ld_stall1", mem_stall, 1'b1);
        chk("ld_read1", mem_read, 1'b1);
        chk("ld_addr1", mem_addr, 64'h40);
        flush = 1'b1;
        tick();
        chk("ld_stall2", mem_stall, 1'b1);
        chk("ld_hold_rw", EX_MEM_Rw, 5'd2);
        chk("ld_memwb_bubble2", MEM_WB_RegWrite, 1'b0);
        tick();
        flush = 1'b0;
        chk("flush_ignored_rw", EX_MEM_Rw, 5'd2);
        chk("flush_ignored_addr", mem_addr, 64'h40);
        chk("ld_stall3", mem_stall, 1'b1);
        chk("ld_memwb_bubble3", MEM_WB_RegWrite, 1'b0);
        mem_ready = 1'b1;
        mem_rdata = 64'hABCD;
        #1;
        chk("ld_stall_release", mem_stall, 1'b0);
        tick();
        set_ex(0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0);
        chk("ld_memwb_we", MEM_WB_RegWrite, 1'b1);
        chk("ld_memwb_rw", MEM_WB_Rw, 5'd2);
        chk("ld_memwb_data", MEM_WB_Data, 64'hABCD);
        chk("ld_next_rw", EX_MEM_Rw, 5'd4);
        tick();
        chk("ld_next_wb_data", MEM_WB_Data, 64'h9);

        // Timeout: memory never answers
        mem_rdata = 64'hDEAD;
        mem_ready = 1'b0;
        set_ex(1, 1, 1, 0, 1, 5'd6, 64'h80, 64'h0);
        tick();
        set_ex(1, 1, 0, 0, 0, 5'd7, 64'h77, 64'h0);
        nstall = 0;
        for (int i = 0; i < 40 && mem_stall; i++) begin
            chk("to_memwb_bubble", MEM_WB_RegWrite, 1'b0);
            nstall++;
            tick();
        end
        chk("to_stall_cycles", nstall, 15);
        chk("to_abort_read", mem_read, 1'b0);
        chk("to_err_pending", mem_err, 1'b0);
        tick();
        set_ex(0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0);
        chk("to_err_set", mem_err, 1'b1);
        chk("to_no_wb", MEM_WB_RegWrite, 1'b0);
        chk("to_resume_rw", EX_MEM_Rw, 5'd7);
        tick();
        chk("to_resume_wb", MEM_WB_RegWrite, 1'b1);
        chk("to_resume_data", MEM_WB_Data, 64'h77);
        chk("to_err_sticky", mem_err, 1'b1);

        // Reset asserted in the middle of a wait
        set_ex(1, 1, 1, 0, 1, 5'd9, 64'h100, 64'h0);
        tick();
        set_ex(0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0);
        tick();
        chk("rw_read_before", mem_read, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("rw_read", mem_read, 1'b0);
        chk("rw_stall", mem_stall, 1'b0);
        chk("rw_addr", mem_addr, 64'h0);
        chk("rw_exmem_rw", EX_MEM_Rw, 5'd0);
        chk("rw_err", mem_err, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        chk("rw_no_wb", MEM_WB_RegWrite, 1'b0);
        chk("rw_idle_stall", mem_stall, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
